// File: rtl/reg_scoreboard.sv
// Register-file scoreboard and issue controller for long-latency writes.
// Define SCOREBOARD_BYPASS_EN to expose same-cycle writeback clears to hazard checks.
module reg_scoreboard #(
    parameter int MAX_PENDING = 4,
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   id_valid,
    input  logic [4:0]             id_rs1,
    input  logic [4:0]             id_rs2,
    input  logic                   id_rs1_used,
    input  logic                   id_rs2_used,
    input  logic [4:0]             id_rd,
    input  logic                   id_rd_write,
    input  logic                   id_long,
    input  logic                   ex_ready,
    input  logic                   flush,
    input  logic                   wb_valid,
    input  logic [4:0]             wb_rd,
    output logic                   stall,
    output logic                   issue_fire,
    output logic [31:0]            busy_vec,
    output logic [3:0]             pending_cnt,
    output logic                   wb_err,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    logic [31:0] busy_q;
    logic [31:0] busy_eff;
    logic [31:0] busy_n;
    logic [3:0]  cnt_q;
    logic [3:0]  pending_eff;
    logic        wb_err_q;
    logic [STALL_CNT_W-1:0] stall_q;

    logic clr;
    logic set;
    logic raw1;
    logic raw2;
    logic waw;
    logic full;

    // Bit 0 of busy_q is never set, so this also rejects writebacks to x0.
    assign clr = wb_valid & busy_q[wb_rd];

`ifdef SCOREBOARD_BYPASS_EN
    logic [31:0] wb_mask;
    assign wb_mask     = wb_valid ? (32'd1 << wb_rd) : 32'd0;
    assign busy_eff    = busy_q & ~wb_mask;
    assign pending_eff = cnt_q - {3'b000, clr};
`else
    assign busy_eff    = busy_q;
    assign pending_eff = cnt_q;
`endif

    assign raw1 = id_rs1_used & (id_rs1 != 5'd0) & busy_eff[id_rs1];
    assign raw2 = id_rs2_used & (id_rs2 != 5'd0) & busy_eff[id_rs2];
    assign waw  = id_rd_write & (id_rd != 5'd0) & busy_eff[id_rd];
    assign full = id_long & id_rd_write
                & (pending_eff == 4'(MAX_PENDING));

    assign stall      = id_valid & (raw1 | raw2 | waw | full | ~ex_ready);
    assign issue_fire = id_valid & ~stall & ~flush;

    assign set = issue_fire & id_long & id_rd_write & (id_rd != 5'd0);

    // Set is applied after clear so a same-register collision leaves the bit on.
    always_comb begin
        busy_n = busy_q;
        if (clr) busy_n[wb_rd] = 1'b0;
        if (set) busy_n[id_rd] = 1'b1;
        busy_n[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            busy_q   <= '0;
            cnt_q    <= '0;
            wb_err_q <= 1'b0;
            stall_q  <= '0;
        end else begin
            busy_q   <= busy_n;
            wb_err_q <= wb_valid & ~busy_q[wb_rd];
            if (set && !clr)
                cnt_q <= cnt_q + 4'd1;
            else if (clr && !set)
                cnt_q <= cnt_q - 4'd1;
            if (id_valid && stall && (stall_q != '1))
                stall_q <= stall_q + 1'b1;
        end
    end

    assign busy_vec     = busy_q;
    assign pending_cnt  = cnt_q;
    assign wb_err       = wb_err_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard.
// Inputs driven and outputs sampled on the falling edge.
module tb_reg_scoreboard;

    logic        clk;
    logic        resetn;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_rs1_used;
    logic        id_rs2_used;
    logic [4:0]  id_rd;
    logic        id_rd_write;
    logic        id_long;
    logic        ex_ready;
    logic        flush;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        stall;
    logic        issue_fire;
    logic [31:0] busy_vec;
    logic [3:0]  pending_cnt;
    logic        wb_err;
    logic [31:0] stall_cycles;

    int checks = 0;
    int errors = 0;
    int exp_sc = 0;

    reg_scoreboard #(.MAX_PENDING(4), .STALL_CNT_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_rd_write(id_rd_write), .id_long(id_long),
        .ex_ready(ex_ready), .flush(flush),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .stall(stall), .issue_fire(issue_fire), .busy_vec(busy_vec),
        .pending_cnt(pending_cnt), .wb_err(wb_err),
        .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_in();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0;
        id_rs1_used = 0; id_rs2_used = 0;
        id_rd = 0; id_rd_write = 0; id_long = 0;
        ex_ready = 1; flush = 0; wb_valid = 0; wb_rd = 0;
    endtask

    task automatic long_op(input logic [4:0] rd);
        idle_in();
        id_valid = 1; id_long = 1; id_rd_write = 1; id_rd = rd;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        resetn = 0;
        for (int i = 0; i < 2; i++) begin
            {id_valid, id_rs1_used, id_rs2_used, id_rd_write,
             id_long, ex_ready, flush, wb_valid} = 8'($urandom);
            id_rs1 = 5'($urandom); id_rs2 = 5'($urandom);
            id_rd = 5'($urandom); wb_rd = 5'($urandom);
            step();
        end
        idle_in();
        resetn = 1;
        checks++;
        if (busy_vec !== 32'd0) begin
            errors++; $display("FAIL reset_busy got %h want 0", busy_vec);
        end
        checks++;
        if (pending_cnt !== 4'd0) begin
            errors++; $display("FAIL reset_cnt got %0d want 0", pending_cnt);
        end
        checks++;
        if (stall_cycles !== 32'd0) begin
            errors++; $display("FAIL reset_sc got %0d want 0", stall_cycles);
        end
        checks++;
        if (wb_err !== 1'b0) begin
            errors++; $display("FAIL reset_wberr got %b want 0", wb_err);
        end
    endtask

    task automatic test_raw();
        long_op(5'd5);
        #1;
        checks++;
        if (issue_fire !== 1'b1) begin
            errors++; $display("FAIL raw_issue_long got %b want 1", issue_fire);
        end
        step();
        idle_in();
        id_valid = 1; id_rs1 = 5; id_rs1_used = 1;
        #1;
        checks++;
        if (busy_vec !== 32'h20 || pending_cnt !== 4'd1) begin
            errors++;
            $display("FAIL raw_busy got %h/%0d want 20/1", busy_vec, pending_cnt);
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (stall !== 1'b1 || issue_fire !== 1'b0) begin
                errors++; $display("FAIL raw_stall got %b want 1", stall);
            end
            exp_sc++;
            step();
        end
        wb_valid = 1; wb_rd = 5;
        #1;
`ifdef SCOREBOARD_BYPASS_EN
        checks++;
        if (stall !== 1'b0 || issue_fire !== 1'b1) begin
            errors++; $display("FAIL raw_wb_issue got %b want 1", issue_fire);
        end
        step();
        wb_valid = 0; id_valid = 0;
        #1;
`else
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL raw_wb_stall got %b want 1", stall);
        end
        exp_sc++;
        step();
        wb_valid = 0;
        #1;
        checks++;
        if (stall !== 1'b0 || issue_fire !== 1'b1) begin
            errors++; $display("FAIL raw_after_issue got %b want 1", issue_fire);
        end
`endif
        checks++;
        if (busy_vec !== 32'd0 || pending_cnt !== 4'd0) begin
            errors++;
            $display("FAIL raw_clear got %h/%0d want 0/0", busy_vec, pending_cnt);
        end
        step();
        idle_in();
    endtask

    task automatic test_budget();
        logic [4:0] rds [4];
        rds[0] = 1; rds[1] = 2; rds[2] = 3; rds[3] = 4;
        for (int i = 0; i < 4; i++) begin
            long_op(rds[i]);
            #1;
            checks++;
            if (issue_fire !== 1'b1) begin
                errors++; $display("FAIL budget_issue%0d got %b want 1", i, issue_fire);
            end
            step();
        end
        long_op(5'd6);
        #1;
        checks++;
        if (pending_cnt !== 4'd4 || stall !== 1'b1) begin
            errors++;
            $display("FAIL budget_full got cnt=%0d stall=%b want 4/1", pending_cnt, stall);
        end
        exp_sc++;
        step();
        wb_valid = 1; wb_rd = 2;
        #1;
`ifdef SCOREBOARD_BYPASS_EN
        checks++;
        if (issue_fire !== 1'b1) begin
            errors++; $display("FAIL budget_wb_issue got %b want 1", issue_fire);
        end
        step();
        idle_in();
`else
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL budget_wb_stall got %b want 1", stall);
        end
        exp_sc++;
        step();
        wb_valid = 0;
        #1;
        checks++;
        if (issue_fire !== 1'b1) begin
            errors++; $display("FAIL budget_late_issue got %b want 1", issue_fire);
        end
        step();
        idle_in();
`endif
        #1;
        checks++;
        if (busy_vec !== 32'h5A || pending_cnt !== 4'd4) begin
            errors++;
            $display("FAIL budget_final got %h/%0d want 5a/4", busy_vec, pending_cnt);
        end
        rds[1] = 6;
        for (int i = 0; i < 4; i++) begin
            wb_valid = 1; wb_rd = rds[i];
            step();
        end
        idle_in();
        #1;
        checks++;
        if (busy_vec !== 32'd0 || pending_cnt !== 4'd0 || wb_err !== 1'b0) begin
            errors++;
            $display("FAIL budget_drain got %h/%0d/%b want 0/0/0",
                     busy_vec, pending_cnt, wb_err);
        end
    endtask

    task automatic test_x0_badwb();
        long_op(5'd0);
        #1;
        checks++;
        if (issue_fire !== 1'b1) begin
            errors++; $display("FAIL x0_issue got %b want 1", issue_fire);
        end
        step();
        idle_in();
        #1;
        checks++;
        if (busy_vec !== 32'd0 || pending_cnt !== 4'd0) begin
            errors++;
            $display("FAIL x0_state got %h/%0d want 0/0", busy_vec, pending_cnt);
        end
        wb_valid = 1; wb_rd = 7;
        #1;
        checks++;
        if (wb_err !== 1'b0) begin
            errors++; $display("FAIL badwb_early got %b want 0", wb_err);
        end
        step();
        wb_valid = 0;
        #1;
        checks++;
        if (wb_err !== 1'b1 || busy_vec !== 32'd0 || pending_cnt !== 4'd0) begin
            errors++;
            $display("FAIL badwb_pulse got err=%b %h/%0d want 1 0/0",
                     wb_err, busy_vec, pending_cnt);
        end
        step();
        checks++;
        if (wb_err !== 1'b0) begin
            errors++; $display("FAIL badwb_drop got %b want 0", wb_err);
        end
    endtask

    task automatic test_flush_waw();
        long_op(5'd9);
        step();
        idle_in();
        id_valid = 1; id_rd_write = 1; id_rd = 9; flush = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (stall !== 1'b1 || issue_fire !== 1'b0 || busy_vec[9] !== 1'b1) begin
                errors++;
                $display("FAIL waw_flush got stall=%b fire=%b busy9=%b want 1/0/1",
                         stall, issue_fire, busy_vec[9]);
            end
            exp_sc++;
            step();
        end
        idle_in();
        id_valid = 1; ex_ready = 0;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL exready_stall got %b want 1", stall);
        end
        exp_sc++;
        step();
        ex_ready = 1; flush = 1;
        #1;
        checks++;
        if (stall !== 1'b0 || issue_fire !== 1'b0) begin
            errors++;
            $display("FAIL flush_noissue got stall=%b fire=%b want 0/0", stall, issue_fire);
        end
        step();
        idle_in();
        #1;
        checks++;
        if (stall_cycles !== 32'(exp_sc)) begin
            errors++; $display("FAIL stall_count got %0d want %0d", stall_cycles, exp_sc);
        end
    endtask

    task automatic test_simul();
`ifdef SCOREBOARD_BYPASS_EN
        long_op(5'd9);
        wb_valid = 1; wb_rd = 9;
        #1;
        checks++;
        if (issue_fire !== 1'b1) begin
            errors++; $display("FAIL simul_issue got %b want 1", issue_fire);
        end
        step();
        idle_in();
        #1;
        checks++;
        if (busy_vec !== 32'h200 || pending_cnt !== 4'd1) begin
            errors++;
            $display("FAIL simul_state got %h/%0d want 200/1", busy_vec, pending_cnt);
        end
`endif
        wb_valid = 1; wb_rd = 9;
        step();
        idle_in();
        #1;
        checks++;
        if (busy_vec !== 32'd0 || pending_cnt !== 4'd0) begin
            errors++;
            $display("FAIL final_clear got %h/%0d want 0/0", busy_vec, pending_cnt);
        end
    endtask

    initial begin
        idle_in();
        resetn = 0;
        step();
        test_reset();
        step();
        test_raw();
        test_budget();
        test_x0_badwb();
        test_flush_waw();
        test_simul();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
